// File: rtl/ieeedrv_rom_loader_pkg.sv
// Shared drive-ROM definitions used by the ROM multiplexer and the ROM write agents.
package ieeedrv_pkg;

  localparam int         ROM_MUX_OFFSET = 3;
  localparam logic [2:0] ROM_SLOT_IDLE  = 3'd7;

  typedef enum logic [1:0] {LD_IDLE, LD_PEND, LD_WRITE} ldr_state_t;

endpackage

// File: rtl/ieeedrv_slot_timer.sv
// Tracks position inside the per-ph2 ROM read schedule and flags the idle slot.
module ieeedrv_slot_timer
  import ieeedrv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ph2,
  output logic [2:0] slot_cnt,
  output logic       win
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= ROM_SLOT_IDLE;
    end else if (ph2) begin
      slot_cnt <= '0;
    end else if (slot_cnt != ROM_SLOT_IDLE) begin
      slot_cnt <= slot_cnt + 3'd1;
    end
  end

  // ph2 restarts the schedule, so it closes the window even at the idle count
  assign win = (slot_cnt == ROM_SLOT_IDLE) && !ph2;

endmodule

// File: rtl/ieeedrv_rom_loader.sv
// Writes the HPS ioctl download stream into the shared drive ROM, one byte per idle slot.
module ieeedrv_rom_loader
  import ieeedrv_pkg::*;
#(
  parameter int          NDR       = 4,
  parameter int          ADDRWIDTH = 14,
  parameter logic [7:0]  INDEX     = 8'd0,
  parameter logic [24:0] ADDR_BASE = 25'd0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ph2,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_data,
  output logic                 ioctl_wait,
  output logic [ADDRWIDTH-1:0] rom_addr,
  output logic [7:0]           rom_data,
  output logic                 rom_wren,
  output logic                 drv_hold,
  output logic                 rom_loaded
);

  logic [2:0]  slot_cnt;
  logic        win;
  logic        slot_free;
  logic        active;
  logic        in_range;
  logic [24:0] off;
  ldr_state_t  state;

  ieeedrv_slot_timer u_slot_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .ph2      (ph2),
    .slot_cnt (slot_cnt),
    .win      (win)
  );

  // The last read slot is NDR+OFFSET-1; the write slot must lie beyond it
  assign slot_free = win && (slot_cnt > 3'(NDR + ROM_MUX_OFFSET - 1));

  assign active   = ioctl_download && (ioctl_index == INDEX);
  assign off      = ioctl_addr - ADDR_BASE;
  assign in_range = (ioctl_addr >= ADDR_BASE) && ((off >> ADDRWIDTH) == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drv_hold <= 1'b0;
    end else begin
      drv_hold <= active;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LD_IDLE;
      ioctl_wait <= 1'b0;
      rom_wren   <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      rom_loaded <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (ioctl_wr && active && in_range) begin
            rom_addr   <= off[ADDRWIDTH-1:0];
            rom_data   <= ioctl_data;
            ioctl_wait <= 1'b1;
            state      <= LD_PEND;
          end
        end
        LD_PEND: begin
          if (slot_free) begin
            rom_wren <= 1'b1;
            state    <= LD_WRITE;
          end
        end
        LD_WRITE: begin
          rom_wren   <= 1'b0;
          ioctl_wait <= 1'b0;
          rom_loaded <= 1'b1;
          state      <= LD_IDLE;
        end
        default: begin
          state <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ieeedrv_rom_loader.sv
// Scoreboard bench for ieeedrv_rom_loader: two instances (ROM base 0 and 0x4000) share one ioctl stream.
module tb_ieeedrv_rom_loader;

  localparam logic [24:0] BASE0 = 25'h0000;
  localparam logic [24:0] BASE1 = 25'h4000;

  typedef struct packed {
    logic [13:0] a;
    logic [7:0]  d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ph2 = 1'b0;
  logic        download = 1'b0;
  logic [7:0]  index = 8'd0;
  logic        wr = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  data = '0;

  logic        wait0, wren0, hold0, loaded0;
  logic [13:0] addr0;
  logic [7:0]  rdata0;
  logic        wait1, wren1, hold1, loaded1;
  logic [13:0] addr1;
  logic [7:0]  rdata1;

  int   tests = 0;
  int   fails = 0;
  int   ph2_period = 16;
  int   ph2_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [2:0] mcnt;
  logic win_q;
  logic prev_wren0 = 1'b0;
  logic prev_wren1 = 1'b0;

  ieeedrv_rom_loader #(.NDR(4), .ADDRWIDTH(14), .INDEX(8'd0), .ADDR_BASE(BASE0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ph2(ph2), .ioctl_download(download),
    .ioctl_index(index), .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_data(data),
    .ioctl_wait(wait0), .rom_addr(addr0), .rom_data(rdata0), .rom_wren(wren0),
    .drv_hold(hold0), .rom_loaded(loaded0)
  );

  ieeedrv_rom_loader #(.NDR(4), .ADDRWIDTH(14), .INDEX(8'd0), .ADDR_BASE(BASE1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ph2(ph2), .ioctl_download(download),
    .ioctl_index(index), .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_data(data),
    .ioctl_wait(wait1), .rom_addr(addr1), .rom_data(rdata1), .rom_wren(wren1),
    .drv_hold(hold1), .rom_loaded(loaded1)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    if (ph2_cnt >= ph2_period - 1) begin
      ph2 = 1'b1;
      ph2_cnt = 0;
    end else begin
      ph2 = 1'b0;
      ph2_cnt++;
    end
  end

  // Reference slot model: win_q says whether the last edge was allowed to launch a write.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt  <= 3'd7;
      win_q <= 1'b0;
    end else begin
      win_q <= (mcnt == 3'd7) && !ph2;
      if (ph2) mcnt <= 3'd0;
      else if (mcnt != 3'd7) mcnt <= mcnt + 3'd1;
    end
  end

  always @(negedge clk) begin
    if (wren0 === 1'b1) begin
      tests++;
      if (win_q !== 1'b1 || prev_wren0 !== 1'b0) begin
        fails++;
        $display("FAIL wren0_slot: win=%0b prev_wren=%0b, required win=1 prev_wren=0", win_q, prev_wren0);
      end
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL wren0_unexpected: addr=%h data=%h, required no write", addr0, rdata0);
      end else begin
        e0 = q0.pop_front();
        if (addr0 !== e0.a || rdata0 !== e0.d) begin
          fails++;
          $display("FAIL wren0_payload: addr=%h data=%h, required addr=%h data=%h", addr0, rdata0, e0.a, e0.d);
        end
      end
    end
    prev_wren0 <= wren0;
  end

  always @(negedge clk) begin
    if (wren1 === 1'b1) begin
      tests++;
      if (win_q !== 1'b1 || prev_wren1 !== 1'b0) begin
        fails++;
        $display("FAIL wren1_slot: win=%0b prev_wren=%0b, required win=1 prev_wren=0", win_q, prev_wren1);
      end
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL wren1_unexpected: addr=%h data=%h, required no write", addr1, rdata1);
      end else begin
        e1 = q1.pop_front();
        if (addr1 !== e1.a || rdata1 !== e1.d) begin
          fails++;
          $display("FAIL wren1_payload: addr=%h data=%h, required addr=%h data=%h", addr1, rdata1, e1.a, e1.d);
        end
      end
    end
    prev_wren1 <= wren1;
  end

  // Drives one ioctl_wr; pushes the expected ROM write for each instance that should accept it.
  task automatic send(input logic [24:0] a, input logic [7:0] d, input logic busy,
                      output logic acc0, output logic acc1);
    logic [24:0] off;
    exp_t e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    wr = 1'b1;
    addr = a;
    data = d;
    if (download && index == 8'd0 && !busy) begin
      off = a - BASE0;
      if (a >= BASE0 && off < 25'h4000) begin
        acc0 = 1'b1; e.a = off[13:0]; e.d = d; q0.push_back(e);
      end
      off = a - BASE1;
      if (a >= BASE1 && off < 25'h4000) begin
        acc1 = 1'b1; e.a = off[13:0]; e.d = d; q1.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic wait_ph2;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ph2 !== 1'b1 && n < 64);
    tests++;
    if (ph2 !== 1'b1) begin
      fails++;
      $display("FAIL ph2_sync: ph2 not seen in %0d cycles, required within 64", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while ((wait0 || wait1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (wait0 !== 1'b0 || wait1 !== 1'b0) begin
      fails++;
      $display("FAIL wait_timeout: wait0=%0b wait1=%0b after %0d cycles, required 0 0", wait0, wait1, n);
    end
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if ({wait0, wren0, addr0, rdata0, hold0, loaded0} !== '0 ||
        {wait1, wren1, addr1, rdata1, hold1, loaded1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: dut0=%b dut1=%b, required all zero",
               {wait0, wren0, addr0, rdata0, hold0, loaded0}, {wait1, wren1, addr1, rdata1, hold1, loaded1});
    end
    #20;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    download = 1'b1;
    index = 8'd0;
  endtask

  task automatic test_basic_write;
    int n;
    logic a0, a1;
    ph2_period = 16;
    wait_ph2();
    @(posedge clk);
    #1;
    send(25'h0005, 8'hA5, 1'b0, a0, a1);
    @(negedge clk);
    tests++;
    if (wait0 !== 1'b1 || wait1 !== 1'b0) begin
      fails++;
      $display("FAIL basic_wait_rise: wait0=%0b wait1=%0b, required 1 0", wait0, wait1);
    end
    n = 1;
    while (wren0 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 7) begin
      fails++;
      $display("FAIL basic_latency: wren after %0d cycles, required 7", n);
    end
    @(negedge clk);
    tests++;
    if (wait0 !== 1'b0 || wren0 !== 1'b0 || loaded0 !== 1'b1 || loaded1 !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: wait=%0b wren=%0b loaded0=%0b loaded1=%0b, required 0 0 1 0",
               wait0, wren0, loaded0, loaded1);
    end
  endtask

  task automatic test_late_window;
    int n;
    logic a0, a1;
    ph2_period = 9;
    wait_ph2();
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    send(25'h0123, 8'h5A, 1'b0, a0, a1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wren0 !== 1'b1 && n < 40);
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL late_window_latency: wren after %0d cycles, required 2", n);
    end
    @(negedge clk);
    tests++;
    if (wait0 !== 1'b0) begin
      fails++;
      $display("FAIL late_window_wait: wait0=%0b, required 0 before ph2", wait0);
    end
    ph2_period = 16;
  endtask

  task automatic test_addr_range;
    logic a0, a1;
    wait_ph2();
    tests++;
    if (loaded1 !== 1'b0) begin
      fails++;
      $display("FAIL range_loaded_before: loaded1=%0b, required 0", loaded1);
    end
    send(25'h3FFF, 8'h11, 1'b0, a0, a1);
    @(negedge clk);
    tests++;
    if (wait0 !== a0 || wait1 !== a1) begin
      fails++;
      $display("FAIL range_3fff: wait0=%0b wait1=%0b, required %0b %0b", wait0, wait1, a0, a1);
    end
    wait_done();
    send(25'h8000, 8'h22, 1'b0, a0, a1);
    @(negedge clk);
    tests++;
    if (wait0 !== a0 || wait1 !== a1) begin
      fails++;
      $display("FAIL range_8000: wait0=%0b wait1=%0b, required %0b %0b", wait0, wait1, a0, a1);
    end
    wait_done();
    send(25'h7FFF, 8'h33, 1'b0, a0, a1);
    @(negedge clk);
    tests++;
    if (wait0 !== a0 || wait1 !== a1) begin
      fails++;
      $display("FAIL range_7fff: wait0=%0b wait1=%0b, required %0b %0b", wait0, wait1, a0, a1);
    end
    wait_done();
    send(25'h4000, 8'h44, 1'b0, a0, a1);
    wait_done();
    @(negedge clk);
    tests++;
    if (loaded1 !== 1'b1 || q1.size() != 0) begin
      fails++;
      $display("FAIL range_loaded_after: loaded1=%0b pending=%0d, required 1 0", loaded1, q1.size());
    end
  endtask

  task automatic test_index_hold;
    logic a0, a1;
    index = 8'd1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    tests++;
    if (hold0 !== 1'b0 || hold1 !== 1'b0) begin
      fails++;
      $display("FAIL index_hold: hold0=%0b hold1=%0b, required 0 0", hold0, hold1);
    end
    send(25'h0005, 8'h66, 1'b0, a0, a1);
    @(negedge clk);
    tests++;
    if (wait0 !== 1'b0 || wait1 !== 1'b0) begin
      fails++;
      $display("FAIL index_wait: wait0=%0b wait1=%0b, required 0 0", wait0, wait1);
    end
    index = 8'd0;
    download = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    download = 1'b1;
    @(negedge clk);
    tests++;
    if (hold0 !== 1'b0) begin
      fails++;
      $display("FAIL hold_rise_early: hold0=%0b, required 0", hold0);
    end
    @(negedge clk);
    tests++;
    if (hold0 !== 1'b1) begin
      fails++;
      $display("FAIL hold_rise: hold0=%0b, required 1", hold0);
    end
    @(posedge clk);
    #1;
    download = 1'b0;
    @(negedge clk);
    tests++;
    if (hold0 !== 1'b1) begin
      fails++;
      $display("FAIL hold_fall_early: hold0=%0b, required 1", hold0);
    end
    @(negedge clk);
    tests++;
    if (hold0 !== 1'b0) begin
      fails++;
      $display("FAIL hold_fall: hold0=%0b, required 0", hold0);
    end
    @(posedge clk);
    #1;
    download = 1'b1;
  endtask

  task automatic test_short_period;
    logic a0, a1;
    logic bad;
    ph2_period = 6;
    wait_ph2();
    send(25'h0010, 8'h3C, 1'b0, a0, a1);
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (wait0 !== 1'b1 || wren0 !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL short_period_stall: wait0=%0b wren0=%0b seen, required wait=1 wren=0 throughout", wait0, wren0);
    end
    ph2_period = 16;
    wait_done();
    tests++;
    if (q0.size() != 0 || loaded0 !== 1'b1) begin
      fails++;
      $display("FAIL short_period_resume: pending=%0d loaded0=%0b, required 0 1", q0.size(), loaded0);
    end
  endtask

  task automatic test_back_to_back;
    logic a0, a1, b0, b1;
    wait_ph2();
    send(25'h0030, 8'h11, 1'b0, a0, a1);
    send(25'h0031, 8'h22, 1'b1, b0, b1);
    wait_done();
    send(25'h0032, 8'h33, 1'b0, a0, a1);
    @(negedge clk);
    tests++;
    if (wait0 !== a0) begin
      fails++;
      $display("FAIL b2b_second_wait: wait0=%0b, required %0b", wait0, a0);
    end
    wait_done();
    @(negedge clk);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain: pending0=%0d pending1=%0d, required 0 0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset_pending;
    logic a0, a1;
    logic bad;
    wait_ph2();
    send(25'h0020, 8'h77, 1'b0, a0, a1);
    @(negedge clk);
    tests++;
    if (wait0 !== 1'b1) begin
      fails++;
      $display("FAIL rst_pend_wait: wait0=%0b, required 1", wait0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (wait0 !== 1'b0 || loaded0 !== 1'b0 || loaded1 !== 1'b0 || wren0 !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: wait0=%0b loaded0=%0b loaded1=%0b wren0=%0b, required 0 0 0 0",
               wait0, loaded0, loaded1, wren0);
    end
    q0.delete();
    q1.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (wren0 !== 1'b0 || wait0 !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL rst_no_write: wren0=%0b wait0=%0b seen, required both 0 throughout", wren0, wait0);
    end
    @(posedge clk);
    #1;
    send(25'h0021, 8'h88, 1'b0, a0, a1);
    wait_done();
    @(negedge clk);
    tests++;
    if (loaded0 !== 1'b1 || q0.size() != 0) begin
      fails++;
      $display("FAIL rst_rewrite: loaded0=%0b pending=%0d, required 1 0", loaded0, q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_late_window();
    test_addr_range();
    test_index_hold();
    test_short_period();
    test_back_to_back();
    test_reset_pending();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
